// File: rtl/reg_checker_pkg.sv
// Shared types and default widths for the register-state checker.
package reg_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } chk_state_e;

    localparam int unsigned DefXlen       = 32;
    localparam int unsigned DefRegAw      = 5;
    localparam int unsigned DefNumChecks  = 3;
    localparam int unsigned DefWaitCycles = 15;

endpackage

// File: rtl/pc_stable_detector.sv
// Flags a halted core: pc unchanged for HALT_STABLE consecutive cycles.
module pc_stable_detector #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HALT_STABLE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            halted
);

    localparam int unsigned CntW = $clog2(HALT_STABLE + 1);

    logic [XLEN-1:0] prev_pc;
    logic [CntW-1:0] stable_cnt;
    logic            same;

    assign same   = (pc == prev_pc);
    // Current cycle counts toward the run, hence the +1.
    assign halted = same && ((32'(stable_cnt) + 32'd1) >= HALT_STABLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc    <= '0;
            stable_cnt <= '0;
        end else begin
            prev_pc <= pc;
            if (!same) begin
                stable_cnt <= '0;
            end else if (32'(stable_cnt) < HALT_STABLE) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_state_checker.sv
// Post-run register-file checker: settle, scan (index, expected) pairs, report.
// Optional halt detection on pc when REG_CHECKER_HALT_DETECT_EN is defined.
module reg_state_checker
    import reg_checker_pkg::*;
#(
    parameter int unsigned XLEN        = DefXlen,
    parameter int unsigned REG_AW      = DefRegAw,
    parameter int unsigned NUM_CHECKS  = DefNumChecks,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles,
    parameter logic [NUM_CHECKS*REG_AW-1:0] CHECK_IDX = {5'd3, 5'd2, 5'd1},
    parameter logic [NUM_CHECKS*XLEN-1:0]   CHECK_VAL = {32'd20, 32'd15, 32'd5}
`ifdef REG_CHECKER_HALT_DETECT_EN
    ,
    parameter int unsigned HALT_STABLE = 4
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [REG_AW-1:0]                   rf_raddr,
    input  logic [XLEN-1:0]                     rf_rdata,
    input  logic [XLEN-1:0]                     pc,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [$clog2(NUM_CHECKS+1)-1:0]     fail_count,
    output logic [REG_AW-1:0]                   first_fail_idx,
    output logic [XLEN-1:0]                     first_fail_got,
    output logic                                timeout
);

    localparam int unsigned KW    = $clog2(NUM_CHECKS + 1);
    localparam int unsigned WaitW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    chk_state_e        state;
    logic [WaitW-1:0]  wait_cnt;
    logic [KW-1:0]     scan_k;
    logic              timeout_q;
    logic              halted;
    logic [REG_AW-1:0] cur_idx;
    logic [XLEN-1:0]   exp_val;
    logic              mismatch;

`ifdef REG_CHECKER_HALT_DETECT_EN
    localparam bit HaltEn = 1'b1;

    pc_stable_detector #(
        .XLEN        (XLEN),
        .HALT_STABLE (HALT_STABLE)
    ) u_pc_stable (
        .clk    (clk),
        .rst    (rst),
        .pc     (pc),
        .halted (halted)
    );
`else
    localparam bit HaltEn = 1'b0;
    logic unused_pc;

    assign unused_pc = ^pc;
    assign halted    = 1'b0;
`endif

    // scan_k selects the address to issue and, one behind, the value to compare.
    always_comb begin
        cur_idx = '0;
        exp_val = '0;
        for (int i = 0; i < int'(NUM_CHECKS); i++) begin
            if (scan_k == KW'(i))     cur_idx = CHECK_IDX[i*REG_AW +: REG_AW];
            if (scan_k == KW'(i + 1)) exp_val = CHECK_VAL[i*XLEN +: XLEN];
        end
    end

    assign mismatch = (rf_rdata !== exp_val);
    assign timeout  = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            scan_k         <= '0;
            rf_raddr       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            timeout_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= (WAIT_CYCLES == 0) ? SCAN : WAIT;
                        wait_cnt       <= '0;
                        scan_k         <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        first_fail_got <= '0;
                        timeout_q      <= 1'b0;
                    end
                end
                WAIT: begin
                    if (halted) begin
                        state <= SCAN;
                    end else if (wait_cnt == WaitW'(WAIT_CYCLES - 1)) begin
                        state     <= SCAN;
                        timeout_q <= HaltEn;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_k < KW'(NUM_CHECKS)) begin
                        rf_raddr <= cur_idx;
                    end
                    if (scan_k != '0 && mismatch) begin
                        if (fail_count == '0) begin
                            first_fail_idx <= rf_raddr;
                            first_fail_got <= rf_rdata;
                        end
                        if (fail_count < KW'(NUM_CHECKS)) begin
                            fail_count <= fail_count + 1'b1;
                        end
                    end
                    if (scan_k == KW'(NUM_CHECKS)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_count == '0) && !mismatch;
                    end else begin
                        scan_k <= scan_k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
